sample_timer_ctrl: RTL and testbench
====================================

Name: sample_timer_ctrl

Overview:
- Sequencer that sits directly upstream of the 16-bit preset/enable down-counter timer (Counter_RV1) and consumes its Zero output.
- Reloads the timer with a sampling interval, waits for expiry, then issues a measurement start request to a sensor FSM and waits for its completion.
- Counts completed samples and raises an interrupt per batch.
- Includes a completion timeout watchdog.

Parameters:
- Width, 16, width of the interval and PresetVal_o; matches the timer width.
- CntWidth, 8, width of the batch size input and the sample counter.
- TimeoutCycles, 1024, maximum cycles Start_o may stay high without Done_i before an error is flagged; must be ≥2.

Ports:
- Clk_i  input  1  clock; all logic on the rising edge.
- Reset_n_i  input  1  reset; synchronous, active-low.
- Enable_i  input  1  run/stop for the sequencer.
- Interval_i  input  Width  timer reload value, captured in LOAD.
- Samples_i  input  CntWidth  batch size (0 is treated as 1), captured in LOAD.
- TmrPreset_o  output  1  to timer Preset_i.
- TmrEnable_o  output  1  to timer Enable_i.
- TmrPresetVal_o  output  Width  to timer PresetVal_i.
- TmrZero_i  input  1  from timer Zero_o; combinational from the timer's count register.
- Start_o  output  1  measurement request to the sensor FSM (level).
- Done_i  input  1  measurement complete (pulse or level).
- Irq_o  output  1  one-cycle pulse when a batch completes.
- SampleCnt_o  output  CntWidth  samples completed in the current batch.
- Error_o  output  1  sticky timeout flag.

Behaviour:
- Reset (Reset_n_i=0 at a rising edge):
  - State goes to IDLE.
  - All outputs are 0, SampleCnt_o=0, TmrPresetVal_o=0.
  - The internal timeout counter is cleared.
  - Reset takes priority over every other event, including mid-MEASURE; Start_o drops on the next edge.
- All outputs are registered or decoded from the state register only; there are no combinational input-to-output paths.
- FSM states: IDLE, LOAD, WAIT, MEASURE.
- IDLE:
  - TmrPreset_o=0, TmrEnable_o=0, Start_o=0.
  - Enable_i=1 → LOAD.
  - On this transition Error_o clears and SampleCnt_o clears.
- LOAD (exactly 1 cycle):
  - TmrPreset_o=1; TmrPresetVal_o=Interval_i, registered and held stable until the next LOAD.
  - Batch size is latched, with 0 mapped to 1.
  - Next state is WAIT.
- WAIT:
  - TmrEnable_o=1.
  - TmrZero_i=1 → MEASURE; this check takes priority over the decrement.
  - Enable_i=0 with TmrZero_i=0 → IDLE.
  - Interval N≥1: WAIT lasts N cycles, so Start_o rises N+1 cycles after LOAD.
  - Interval 0: WAIT lasts 1 cycle.
  - Timer wrap-around is impossible because the FSM leaves WAIT on Zero.
- MEASURE:
  - Start_o=1, TmrEnable_o=0; the timeout counter increments every cycle.
  - Done_i=1:
    - Start_o drops on the next edge and SampleCnt_o increments.
    - If SampleCnt_o+1 equals the batch size: Irq_o=1 for the next cycle and SampleCnt_o goes to 0.
    - Next state is LOAD if Enable_i=1, else IDLE.
  - Enable_i=0 does not abort MEASURE; the FSM waits for Done_i or timeout.
  - Timeout counter reaches TimeoutCycles-1 without Done_i: Error_o=1, Start_o=0, no count, no Irq_o, → IDLE.
  - Done_i on the same cycle as the timeout is treated as Done; no error.
- Done_i in any state other than MEASURE is ignored.
- Sample period with Enable_i held high = 1 (LOAD) + max(N,1) (WAIT) + M, where M is the number of MEASURE cycles including the Done cycle.
- The FSM restarts from IDLE after an error only when Enable_i is high; a level-held Enable_i therefore restarts immediately and clears Error_o.
- SampleCnt_o arithmetic is modulo 2^CntWidth. It cannot overflow, because the batch size is ≤2^CntWidth-1 and the counter clears at batch end.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOAD, WAIT, MEASURE) with a 2-bit encoding;
  - default Width/CntWidth constants shared with the timer cell.
- One sub-module: timeout_watchdog, a clear/enable up-counter with a terminal-count flag parameterised by TimeoutCycles.
- Integration wrapper sample_timer_node instantiates this block plus the Counter_RV1 timer.

Test Plan:
- Reset/idle: Reset_n_i=0 for 2 cycles while Enable_i=1 → all outputs 0, state IDLE; release → TmrPreset_o=1 on the next cycle with TmrPresetVal_o=Interval_i.
- Basic period (real timer attached): Interval_i=5, Samples_i=3, Done_i pulse 2 cycles after each Start_o rise →
  - Start_o rises 6 cycles after LOAD;
  - SampleCnt_o goes 1,2,0;
  - one Irq_o pulse after the 3rd Done_i;
  - period is 9 cycles.
- Zero interval: Interval_i=0, Samples_i=0, Done_i tied high → Start_o high 1 cycle per period, Irq_o on every sample, period 3 cycles.
- Stop during WAIT: Interval_i=100, drop Enable_i 10 cycles into WAIT → IDLE next edge, TmrEnable_o=0, no Start_o.
- Stop during MEASURE: drop Enable_i while Start_o=1, Done_i 4 cycles later → count increments, then IDLE with no LOAD.
- Timeout: TimeoutCycles=16, Done_i held 0 → Error_o=1 and Start_o=0 after 16 MEASURE cycles, no Irq_o; Done_i on cycle 16 instead → no error.

Source files
------------

// File: rtl/sample_timer_ctrl_pkg.sv
// Shared types and default widths for the sample timer sequencer and its timer cell.
package sample_timer_ctrl_pkg;

  localparam int unsigned DefaultWidth    = 16;
  localparam int unsigned DefaultCntWidth = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StWait    = 2'd2,
    StMeasure = 2'd3
  } state_e;

endpackage

// File: rtl/sample_timer_ctrl_timeout_watchdog.sv
// Clear/enable up-counter flagging when it sits at TimeoutCycles-1.
module sample_timer_ctrl_timeout_watchdog
  import sample_timer_ctrl_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] Terminal = CW'(TimeoutCycles - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != Terminal)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == Terminal);

endmodule

// File: rtl/sample_timer_ctrl.sv
// Interval sequencer: reload timer, wait for Zero, run one measurement, count batch, watchdog.
module sample_timer_ctrl
  import sample_timer_ctrl_pkg::*;
#(
  parameter int unsigned Width         = DefaultWidth,
  parameter int unsigned CntWidth      = DefaultCntWidth,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                Clk_i,
  input  logic                Reset_n_i,
  input  logic                Enable_i,
  input  logic [Width-1:0]    Interval_i,
  input  logic [CntWidth-1:0] Samples_i,
  output logic                TmrPreset_o,
  output logic                TmrEnable_o,
  output logic [Width-1:0]    TmrPresetVal_o,
  input  logic                TmrZero_i,
  output logic                Start_o,
  input  logic                Done_i,
  output logic                Irq_o,
  output logic [CntWidth-1:0] SampleCnt_o,
  output logic                Error_o
);

  state_e state_q, state_d;

  logic [Width-1:0]    preset_val_q;
  logic [CntWidth-1:0] batch_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_inc;
  logic                irq_q;
  logic                err_q;
  logic                wd_expired;
  logic                in_measure;
  logic                done_ev;
  logic                timeout_ev;
  logic                batch_end;
  logic                start_run;

  assign in_measure = (state_q == StMeasure);
  assign done_ev    = in_measure && Done_i;
  // Done on the terminal cycle wins over the timeout.
  assign timeout_ev = in_measure && !Done_i && wd_expired;
  assign cnt_inc    = cnt_q + 1'b1;
  assign batch_end  = done_ev && (cnt_inc == batch_q);
  assign start_run  = (state_q == StIdle) && Enable_i;

  sample_timer_ctrl_timeout_watchdog #(
    .TimeoutCycles (TimeoutCycles)
  ) u_watchdog (
    .clk     (Clk_i),
    .rst_n   (Reset_n_i),
    .clear   (!in_measure),
    .enable  (in_measure),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (Enable_i) state_d = StLoad;
      StLoad:    state_d = StWait;
      StWait: begin
        if (TmrZero_i) begin
          state_d = StMeasure;
        end else if (!Enable_i) begin
          state_d = StIdle;
        end
      end
      StMeasure: begin
        if (Done_i) begin
          state_d = Enable_i ? StLoad : StIdle;
        end else if (wd_expired) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      state_q      <= StIdle;
      preset_val_q <= '0;
      batch_q      <= '0;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= batch_end;
      // Capture on entry so the values are already valid during the LOAD cycle.
      if (state_d == StLoad) begin
        preset_val_q <= Interval_i;
        batch_q      <= (Samples_i == '0) ? {{(CntWidth-1){1'b0}}, 1'b1} : Samples_i;
      end
      if (start_run) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (done_ev) begin
        cnt_q <= batch_end ? '0 : cnt_inc;
      end
      if (timeout_ev) begin
        err_q <= 1'b1;
      end
    end
  end

  assign TmrPreset_o    = (state_q == StLoad);
  assign TmrEnable_o    = (state_q == StWait);
  assign Start_o        = in_measure;
  assign TmrPresetVal_o = preset_val_q;
  assign Irq_o          = irq_q;
  assign SampleCnt_o    = cnt_q;
  assign Error_o        = err_q;

endmodule

// File: tb/tb_sample_timer_ctrl.sv
// Directed + randomized bench for sample_timer_ctrl with a stand-in down-counter timer.
module tb_sample_timer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] interval;
  logic [7:0]  samples;
  logic        tmr_preset;
  logic        tmr_en;
  logic [15:0] tmr_pv;
  logic        tmr_zero;
  logic        start;
  logic        done;
  logic        irq;
  logic [7:0]  cnt;
  logic        err;

  int checks = 0;
  int errors = 0;

  sample_timer_ctrl #(
    .Width         (16),
    .CntWidth      (8),
    .TimeoutCycles (16)
  ) dut (
    .Clk_i          (clk),
    .Reset_n_i      (rst_n),
    .Enable_i       (en),
    .Interval_i     (interval),
    .Samples_i      (samples),
    .TmrPreset_o    (tmr_preset),
    .TmrEnable_o    (tmr_en),
    .TmrPresetVal_o (tmr_pv),
    .TmrZero_i      (tmr_zero),
    .Start_o        (start),
    .Done_i         (done),
    .Irq_o          (irq),
    .SampleCnt_o    (cnt),
    .Error_o        (err)
  );

  // Stand-in timer: Zero shows in the last WAIT cycle, so WAIT spans max(N,1) cycles.
  logic [15:0] tmr_cnt = '0;
  always @(posedge clk) begin
    if (tmr_preset) tmr_cnt <= tmr_pv;
    else if (tmr_en && tmr_cnt != 0) tmr_cnt <= tmr_cnt - 16'd1;
  end
  assign tmr_zero = (tmr_cnt <= 16'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reset, then release with Enable high; returns in the LOAD cycle.
  task automatic do_reset(input logic [15:0] n, input logic [7:0] s);
    rst_n = 1'b0; en = 1'b1; interval = n; samples = s;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("load_preset", tmr_preset, 1);
    check("load_value", tmr_pv, n);
  endtask

  // From a LOAD cycle, step until Start_o rises; c = cycles from LOAD to the rise.
  task automatic wait_start(output int c);
    c = 0;
    forever begin
      tick();
      c++;
      if (start) break;
      if (c == 1) check("irq_one_cycle", irq, 0);
      if (c > 200) begin
        check("start_never_rose", start, 1);
        break;
      end
    end
  endtask

  // From MEASURE cycle 1, hold Done low dly cycles, pulse it, return on the cycle after.
  task automatic finish_measure(input int dly);
    for (int i = 0; i < dly; i++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    int c;
    int n;
    int s;
    int b;
    int dly;
    rst_n = 1'b0; en = 1'b1; interval = 16'd5; samples = 8'd3; done = 1'b0;

    // Reset state with Enable high
    tick(); tick();
    check("rst_preset", tmr_preset, 0);
    check("rst_tmr_en", tmr_en, 0);
    check("rst_pv", tmr_pv, 0);
    check("rst_start", start, 0);
    check("rst_irq", irq, 0);
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    check("rel_preset", tmr_preset, 1);
    check("rel_pv", tmr_pv, 5);

    // Basic period: interval 5, batch 3, Done two cycles after Start
    for (int k = 1; k <= 3; k++) begin
      wait_start(c);
      check("basic_latency", c, 6);
      finish_measure(2);
      check("basic_cnt", cnt, k % 3);
      check("basic_irq", irq, (k == 3) ? 1 : 0);
      check("basic_period_reload", tmr_preset, 1);
      check("basic_start_drop", start, 0);
    end

    // Zero interval, batch 0 (=1), Done tied high: LOAD/WAIT/MEASURE every 3 cycles
    done = 1'b1;
    do_reset(16'd0, 8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("z_wait", tmr_en, 1);
      check("z_wait_start", start, 0);
      tick();
      check("z_meas", start, 1);
      tick();
      check("z_reload", tmr_preset, 1);
      check("z_irq", irq, 1);
      check("z_cnt", cnt, 0);
    end
    done = 1'b0;

    // Stop during WAIT
    do_reset(16'd100, 8'd3);
    for (int i = 0; i < 10; i++) tick();
    check("sw_in_wait", tmr_en, 1);
    en = 1'b0;
    tick();
    check("sw_tmr_en", tmr_en, 0);
    check("sw_start", start, 0);
    for (int i = 0; i < 5; i++) tick();
    check("sw_idle_start", start, 0);
    check("sw_idle_preset", tmr_preset, 0);

    // Stop during MEASURE: finishes the sample, then idles
    do_reset(16'd2, 8'd3);
    wait_start(c);
    check("sm_latency", c, 3);
    en = 1'b0;
    finish_measure(4);
    check("sm_cnt", cnt, 1);
    check("sm_start", start, 0);
    check("sm_no_load", tmr_preset, 0);
    tick();
    check("sm_still_idle", tmr_preset, 0);

    // Timeout with Enable held: error for one IDLE cycle, then restart clears it
    do_reset(16'd1, 8'd2);
    wait_start(c);
    for (int i = 0; i < 15; i++) tick();
    check("to_start_c16", start, 1);
    check("to_no_err_yet", err, 0);
    tick();
    check("to_err", err, 1);
    check("to_start", start, 0);
    check("to_irq", irq, 0);
    check("to_cnt", cnt, 0);
    tick();
    check("to_restart", tmr_preset, 1);
    check("to_err_clr", err, 0);

    // Timeout with Enable low: error stays sticky
    wait_start(c);
    en = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("to2_err", err, 1);
    for (int i = 0; i < 4; i++) tick();
    check("to2_sticky", err, 1);
    en = 1'b1;
    tick();
    check("to2_reload", tmr_preset, 1);
    check("to2_err_clr", err, 0);

    // Done on the 16th MEASURE cycle beats the timeout
    wait_start(c);
    finish_measure(15);
    check("dl_no_err", err, 0);
    check("dl_cnt", cnt, 1);
    check("dl_reload", tmr_preset, 1);

    // Randomized: predicted by interval/batch arithmetic
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(0, 7);
      s = $urandom_range(0, 4);
      b = (s == 0) ? 1 : s;
      do_reset(16'(n), 8'(s));
      for (int k = 1; k <= 2 * b + 1; k++) begin
        dly = $urandom_range(0, 6);
        wait_start(c);
        check("rnd_latency", c, 1 + ((n == 0) ? 1 : n));
        finish_measure(dly);
        check("rnd_cnt", cnt, k % b);
        check("rnd_irq", irq, (k % b == 0) ? 1 : 0);
        check("rnd_reload", tmr_preset, 1);
        check("rnd_pv", tmr_pv, n);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
